replica_swap_sched: RTL and testbench
=====================================

# replica_swap_sched

Parallel-tempering swap scheduler that sits above the array of `replica` instances. After every Metropolis sweep it compares the total tour distances of replicas at neighbouring temperature slots and swaps their slot assignment. Pairing alternates between even and odd rounds. It generalises the fixed two-neighbour exchange into a configurable N-replica scheduler with random-threshold acceptance, a random-source handshake and per-pair acceptance statistics.

## Interface
Parameters:
- `REPLICA_NUM`, 32, number of replicas / temperature slots; ≥2.
- `ENERGY_W`, 27, width of a total-distance value (unsigned).
- `CNT_W`, 16, width of each per-pair acceptance counter.
- `REPLICA_LOG`, `$clog2(REPLICA_NUM)`, derived; id/slot index width.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse requesting a swap round.
- `energy` in `REPLICA_NUM*ENERGY_W`: total distance per replica id; id i occupies bits `[i*ENERGY_W +: ENERGY_W]`.
- `rnd_req` out 1: request for one random threshold.
- `rnd_valid` in 1: random source has data.
- `rnd_data` in `ENERGY_W`: threshold sample, already scaled to energy units (−ln(u)/Δβ).
- `clear_cnt` in 1: zero all acceptance counters.
- `cnt_addr` in `REPLICA_LOG`: pair index k for the counter read.
- `cnt_data` out `CNT_W`: acceptance count of pair (k, k+1).
- `slot_map` out `REPLICA_NUM*REPLICA_LOG`: replica id at each slot; slot 0 is coldest.
- `parity` out 1: parity of the next round.
- `busy` out 1: a round is in progress.
- `done` out 1: one-cycle pulse at the end of a round.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - `start`=1 latches E[s] = energy of replica `slot_map[s]` for every slot s.
  - Sets k = `parity`, then goes to REQ.
  - If `parity`=1 and `REPLICA_NUM`=2, there is no pair: go straight to DONE.
- REQ:
  - `rnd_req`=1. A transfer occurs in any cycle with `rnd_req`&&`rnd_valid`.
  - On transfer, pair (k, k+1) is evaluated. Accept if E[k] ≥ E[k+1], or if (E[k+1]−E[k]) ≤ `rnd_data`, unsigned.
  - Accept action: swap `slot_map[k]`/`slot_map[k+1]` and E[k]/E[k+1], and increment counter k. Counters saturate at all-ones.
  - Exactly one random is consumed per pair, whether or not the pair is accepted.
  - Then k += 2. If k+1 > `REPLICA_NUM`−1 after the increment, go to DONE; else stay in REQ.
- DONE: `done`=1 for one cycle, toggle `parity`, return to IDLE.
- Reads:
  - `cnt_data` is registered from `cnt_addr`, with 1-cycle read latency.
  - For an address ≥ `REPLICA_NUM`−1, `cnt_data`=0.
- `clear_cnt` zeroes all counters on the next edge. If a same-cycle accept increment hits, `clear_cnt` wins.
- `start` while `busy` is ignored, with no queueing.
- `rnd_valid` outside REQ is ignored.
- `energy` is sampled only on the `start` cycle. Later changes do not affect the running round.
- Number of pairs per round:
  - Even parity: floor(N/2).
  - Odd parity: floor((N−1)/2).

## Timing
- Reset values:
  - `slot_map` = identity (slot s holds id s).
  - `parity`=0; `busy`=0, `done`=0, `rnd_req`=0, `cnt_data`=0.
  - All counters 0; state IDLE.
- `busy`=1 in REQ and DONE. It goes high the cycle after `start`.
- `slot_map` updates the cycle after each accepted transfer. It is stable in IDLE.
- With `rnd_valid` tied high, a round of P pairs takes P REQ cycles plus 1 DONE cycle.
  - Start at cycle 0 gives `done` at cycle P+1.
  - A new `start` is accepted at cycle P+2 or later.
- `reset` mid-round: the round is abandoned, all state takes reset values, and there is no `done` pulse.
- Reset asserted together with `start` wins.

## Test plan
- Reset, N=4, then `start` with energies {10,20,30,40} and `rnd_data`=0, `rnd_valid`=1:
  - Even pairs (0,1) and (2,3) are rejected.
  - `done` at cycle 3; `slot_map`={0,1,2,3}; `parity`=1.
- Same configuration, energies {40,30,20,10}:
  - Round 1 (even) gives `slot_map`={1,0,3,2}.
  - Round 2 (odd) swaps pair (1,2), giving {1,3,0,2}.
  - Counters: c0=1, c1=1, c2=1.
- Threshold boundary, E[0]=100, E[1]=150:
  - `rnd_data`=50 → accept.
  - `rnd_data`=49 → reject.
- Handshake: hold `rnd_valid`=0 for 5 cycles in REQ.
  - `rnd_req` stays 1 and no state changes.
  - `done` is delayed by exactly 5 cycles.
  - A `start` pulse while `busy` is ignored.
- Counter saturation: set CNT_W=2 and run 5 accepting rounds on pair 0.
  - Reads: `cnt_addr`=0 gives 3 one cycle later.
  - `clear_cnt` gives 0.
  - `clear_cnt` in the same cycle as an accept still gives 0.
- Assert `reset` during the second REQ cycle.
  - Result: `busy`=0, identity `slot_map`, `parity`=0, no `done`.
  - The next `start` runs a full even round.

Source files
------------

// File: rtl/replica_swap_sched.sv
// Parallel-tempering swap scheduler: after each sweep, walk the neighbouring
// temperature-slot pairs of one parity, accept or reject each exchange against
// a random threshold, and keep per-pair acceptance counts.
module replica_swap_sched #(
    parameter int REPLICA_NUM = 32,
    parameter int ENERGY_W    = 27,
    parameter int CNT_W       = 16,
    parameter int REPLICA_LOG = $clog2(REPLICA_NUM)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [REPLICA_NUM*ENERGY_W-1:0]    energy,
    output logic                               rnd_req,
    input  logic                               rnd_valid,
    input  logic [ENERGY_W-1:0]                rnd_data,
    input  logic                               clear_cnt,
    input  logic [REPLICA_LOG-1:0]             cnt_addr,
    output logic [CNT_W-1:0]                   cnt_data,
    output logic [REPLICA_NUM*REPLICA_LOG-1:0] slot_map,
    output logic                               parity,
    output logic                               busy,
    output logic                               done
);

    // One extra bit so the pair index can step past the last slot.
    localparam int KW = REPLICA_LOG + 1;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic                    parity_q, parity_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rnd_req_q, rnd_req_d;
    logic [CNT_W-1:0]        cnt_data_q, cnt_data_d;
    logic [REPLICA_LOG-1:0]  map_q [REPLICA_NUM];
    logic [REPLICA_LOG-1:0]  map_d [REPLICA_NUM];
    logic [ENERGY_W-1:0]     e_q   [REPLICA_NUM];
    logic [ENERGY_W-1:0]     e_d   [REPLICA_NUM];
    logic [ENERGY_W-1:0]     energy_arr [REPLICA_NUM];
    logic [CNT_W-1:0]        cnt_all [REPLICA_NUM-1];

    logic [REPLICA_LOG-1:0]  k_lo, k_hi;
    logic [ENERGY_W-1:0]     e_lo, e_hi, e_diff;
    logic [KW-1:0]           k_step;
    logic                    xfer, accept, acc_fire, last_pair;

    genvar gi;

    // Unpack the energy bus by replica id and pack the slot map for output.
    generate
        for (gi = 0; gi < REPLICA_NUM; gi++) begin : g_unpack
            assign energy_arr[gi] = energy[gi*ENERGY_W +: ENERGY_W];
            assign slot_map[gi*REPLICA_LOG +: REPLICA_LOG] = map_q[gi];
        end
    endgenerate

    // Pair (k, k+1) evaluation; the difference is only meaningful when e_hi > e_lo.
    assign k_lo      = k_q[REPLICA_LOG-1:0];
    assign k_hi      = k_lo + REPLICA_LOG'(1);
    assign e_lo      = e_q[k_lo];
    assign e_hi      = e_q[k_hi];
    assign e_diff    = e_hi - e_lo;
    assign accept    = (e_lo >= e_hi) || (e_diff <= rnd_data);
    assign xfer      = (state_q == REQ) && rnd_valid;
    assign acc_fire  = xfer && accept;
    assign k_step    = k_q + KW'(2);
    assign last_pair = (k_step >= KW'(REPLICA_NUM - 1));

    // Per-pair saturating acceptance counters; a clear beats a same-cycle increment.
    generate
        for (gi = 0; gi < REPLICA_NUM - 1; gi++) begin : g_cnt
            logic [CNT_W-1:0] c_q, c_d;

            // Next counter value.
            always_comb begin
                c_d = c_q;
                if (clear_cnt) begin
                    c_d = '0;
                end else if (acc_fire && (k_lo == REPLICA_LOG'(gi)) && (c_q != '1)) begin
                    c_d = c_q + CNT_W'(1);
                end
            end

            // Counter register.
            always_ff @(posedge clk) begin
                if (reset) begin
                    c_q <= '0;
                end else begin
                    c_q <= c_d;
                end
            end

            assign cnt_all[gi] = c_q;
        end
    endgenerate

    // Counter read port; addresses past the last pair read as zero.
    always_comb begin
        cnt_data_d = '0;
        if (cnt_addr < REPLICA_LOG'(REPLICA_NUM - 1)) begin
            cnt_data_d = cnt_all[cnt_addr];
        end
    end

    // Round sequencing: latch energies per slot, walk pairs, swap on accept.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        parity_d  = parity_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rnd_req_d = rnd_req_q;
        map_d     = map_q;
        e_d       = e_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int s = 0; s < REPLICA_NUM; s++) begin
                        e_d[s] = energy_arr[map_q[s]];
                    end
                    k_d    = {{(KW-1){1'b0}}, parity_q};
                    busy_d = 1'b1;
                    // Odd parity with two replicas has no pair to evaluate.
                    if (KW'(parity_q) >= KW'(REPLICA_NUM - 1)) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        rnd_req_d = 1'b0;
                    end else begin
                        state_d   = REQ;
                        rnd_req_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (xfer) begin
                    if (accept) begin
                        map_d[k_lo] = map_q[k_hi];
                        map_d[k_hi] = map_q[k_lo];
                        e_d[k_lo]   = e_hi;
                        e_d[k_hi]   = e_lo;
                    end
                    k_d = k_step;
                    if (last_pair) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        rnd_req_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                parity_d = ~parity_q;
            end
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                rnd_req_d = 1'b0;
            end
        endcase
    end

    // FSM and datapath registers; reset abandons any round in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            parity_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rnd_req_q  <= 1'b0;
            cnt_data_q <= '0;
            for (int s = 0; s < REPLICA_NUM; s++) begin
                map_q[s] <= REPLICA_LOG'(s);
                e_q[s]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            parity_q   <= parity_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rnd_req_q  <= rnd_req_d;
            cnt_data_q <= cnt_data_d;
            map_q      <= map_d;
            e_q        <= e_d;
        end
    end

    assign rnd_req  = rnd_req_q;
    assign cnt_data = cnt_data_q;
    assign parity   = parity_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_replica_swap_sched.sv
// Directed bench for replica_swap_sched (4 replicas, 2-bit counters) with a
// reference model that queues per-round expectations for comparison at done.
module tb_replica_swap_sched;

    localparam int N  = 4;
    localparam int EW = 16;
    localparam int CW = 2;
    localparam int LG = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [N*EW-1:0]   energy;
    logic              rnd_req;
    logic              rnd_valid;
    logic [EW-1:0]     rnd_data;
    logic              clear_cnt;
    logic [LG-1:0]     cnt_addr;
    logic [CW-1:0]     cnt_data;
    logic [N*LG-1:0]   slot_map;
    logic              parity;
    logic              busy;
    logic              done;

    replica_swap_sched #(
        .REPLICA_NUM (N),
        .ENERGY_W    (EW),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .energy    (energy),
        .rnd_req   (rnd_req),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .clear_cnt (clear_cnt),
        .cnt_addr  (cnt_addr),
        .cnt_data  (cnt_data),
        .slot_map  (slot_map),
        .parity    (parity),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [N*LG-1:0] map;
        logic            par;
        int              cycles;
    } exp_t;

    exp_t sb[$];

    int m_map [N];
    int m_cnt [N-1];
    int m_par;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*LG-1:0] model_flat();
        logic [N*LG-1:0] f;
        f = '0;
        for (int s = 0; s < N; s++) f[s*LG +: LG] = LG'(m_map[s]);
        return f;
    endfunction

    task automatic model_reset;
        for (int s = 0; s < N; s++) m_map[s] = s;
        for (int s = 0; s < N - 1; s++) m_cnt[s] = 0;
        m_par = 0;
        sb.delete();
    endtask

    // Reference round: clr names the cycle (1-based) carrying clear_cnt.
    task automatic model_round(input int e0, input int e1, input int e2, input int e3,
                               input int rnd, input int stall, input int clr);
        int en [N];
        int e  [N];
        int p;
        int t;
        exp_t x;
        en[0] = e0; en[1] = e1; en[2] = e2; en[3] = e3;
        for (int s = 0; s < N; s++) e[s] = en[m_map[s]];
        p = 0;
        for (int k = m_par; k + 1 <= N - 1; k += 2) begin
            if ((e[k] >= e[k+1]) || ((e[k+1] - e[k]) <= rnd)) begin
                t = m_map[k]; m_map[k] = m_map[k+1]; m_map[k+1] = t;
                t = e[k];     e[k] = e[k+1];         e[k+1] = t;
                if (m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
            end
            p++;
            if (p == clr) begin
                for (int s = 0; s < N - 1; s++) m_cnt[s] = 0;
            end
        end
        m_par ^= 1;
        x.map    = model_flat();
        x.par    = m_par[0];
        x.cycles = p + 1 + stall;
        sb.push_back(x);
    endtask

    task automatic do_round(input int e0, input int e1, input int e2, input int e3,
                            input int rnd, input int stall, input int clr,
                            input bit inject_start, output int cyc);
        int n;
        exp_t x;
        logic [N*LG-1:0] pre;
        pre    = model_flat();
        energy = {EW'(e3), EW'(e2), EW'(e1), EW'(e0)};
        rnd_data = EW'(rnd);
        model_round(e0, e1, e2, e3, rnd, stall, clr);
        start     = 1'b1;
        rnd_valid = (stall == 0);
        n = 0;
        do begin
            tick;
            start = 1'b0;
            n++;
            rnd_valid = (n > stall);
            clear_cnt = (n == clr);
            if (stall > 0 && n <= stall) begin
                check("stall_rnd_req", 32'(rnd_req), 32'd1);
                check("stall_slot_map", 32'(slot_map), 32'(pre));
            end
            if (inject_start && n == 2) start = 1'b1;
        end while (!done && n < 40);
        start     = 1'b0;
        clear_cnt = 1'b0;
        x = sb.pop_front();
        $display("round: done after %0d cycles (want %0d), slot_map=%0h (want %0h)",
                 n, x.cycles, slot_map, x.map);
        check("done_cycle", 32'(n), 32'(x.cycles));
        check("slot_map", 32'(slot_map), 32'(x.map));
        tick;
        check("done_pulse", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("parity", 32'(parity), 32'(x.par));
        cyc = n;
    endtask

    task automatic read_cnt(input int addr, input string tag);
        int exp;
        cnt_addr = LG'(addr);
        tick;
        exp = (addr < N - 1) ? m_cnt[addr] : 0;
        $display("read cnt[%0d] = %0d (want %0d)", addr, cnt_data, exp);
        check(tag, 32'(cnt_data), 32'(exp));
    endtask

    task automatic do_reset;
        reset = 1'b1;
        start = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        model_reset();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rnd_req", 32'(rnd_req), 32'd0);
        check("rst_parity", 32'(parity), 32'd0);
        check("rst_slot_map", 32'(slot_map), 32'hE4);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; start = 1'b0; energy = '0; rnd_valid = 1'b0;
        rnd_data = '0; clear_cnt = 1'b0; cnt_addr = '0;

        // Reset state.
        do_reset();
        check("rst_cnt_data", 32'(cnt_data), 32'd0);

        // Ascending energies, zero threshold: both even pairs rejected.
        do_round(10, 20, 30, 40, 0, 0, 0, 1'b0, cyc);
        check("t1_cycles", 32'(cyc), 32'd3);
        check("t1_map", 32'(slot_map), 32'hE4);
        check("t1_parity", 32'(parity), 32'd1);

        // Descending energies: even round then odd round.
        do_reset();
        do_round(40, 30, 20, 10, 0, 0, 0, 1'b0, cyc);
        check("t2_map_even", 32'(slot_map), 32'hB1);
        do_round(40, 30, 20, 10, 0, 0, 0, 1'b0, cyc);
        check("t2_cycles_odd", 32'(cyc), 32'd2);
        check("t2_map_odd", 32'(slot_map), 32'h8D);
        read_cnt(0, "t2_c0");
        check("t2_c0_const", 32'(cnt_data), 32'd1);
        read_cnt(1, "t2_c1");
        read_cnt(2, "t2_c2");
        check("t2_c2_const", 32'(cnt_data), 32'd1);
        read_cnt(3, "t2_c3_oob");

        // Threshold boundary on pair 0.
        do_reset();
        do_round(100, 150, 0, 0, 50, 0, 0, 1'b0, cyc);
        check("t3_accept", 32'(slot_map[LG-1:0]), 32'd1);
        do_reset();
        do_round(100, 150, 0, 0, 49, 0, 0, 1'b0, cyc);
        check("t3_reject", 32'(slot_map[LG-1:0]), 32'd0);

        // Handshake stall of 5 cycles plus a start pulse while busy.
        do_reset();
        do_round(10, 20, 30, 40, 0, 5, 0, 1'b1, cyc);
        check("t4_cycles", 32'(cyc), 32'd8);

        // Saturation: always-accept threshold over 10 rounds (5 even).
        for (int r = 0; r < 10; r++) begin
            do_round(10, 20, 30, 40, 16'hFFFF, 0, 0, 1'b0, cyc);
        end
        read_cnt(0, "t5_c0_sat");
        check("t5_c0_const", 32'(cnt_data), 32'd3);
        read_cnt(1, "t5_c1_sat");
        clear_cnt = 1'b1;
        tick;
        clear_cnt = 1'b0;
        for (int s = 0; s < N - 1; s++) m_cnt[s] = 0;
        read_cnt(0, "t5_c0_clear");
        // Odd round, then an even round with clear on the pair-0 accept cycle.
        do_round(10, 20, 30, 40, 16'hFFFF, 0, 0, 1'b0, cyc);
        do_round(10, 20, 30, 40, 16'hFFFF, 0, 1, 1'b0, cyc);
        read_cnt(0, "t5_c0_clr_win");
        check("t5_c0_clr_const", 32'(cnt_data), 32'd0);
        read_cnt(1, "t5_c1_after");
        read_cnt(2, "t5_c2_after");

        // Reset during the second REQ cycle of an even round.
        do_round(10, 20, 30, 40, 16'hFFFF, 0, 0, 1'b0, cyc);
        energy    = {EW'(10), EW'(20), EW'(30), EW'(40)};
        rnd_data  = 16'hFFFF;
        rnd_valid = 1'b1;
        start     = 1'b1;
        tick;
        start = 1'b0;
        tick;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick;
            check("abort_no_done", 32'(done), 32'd0);
        end
        read_cnt(0, "abort_c0");
        do_round(10, 20, 30, 40, 0, 0, 0, 1'b0, cyc);
        check("abort_next_cycles", 32'(cyc), 32'd3);
        check("abort_next_parity", 32'(parity), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
